// File: rtl/ui_search_if.sv
// ui_search_if: search request, Ui table lookup and result signals of ui_search.
// The slave side is the search engine; the master side is its requester plus the Ui table.
`default_nettype none

interface ui_search_if;
  logic       start;
  logic [7:0] key;
  logic [7:0] add;
  logic [7:0] Uip;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] match_add;
  logic [8:0] match_cnt;

  modport slave (
    input  start, key, Uip,
    output add, busy, done, found, match_add, match_cnt
  );

  modport master (
    output start, key, Uip,
    input  add, busy, done, found, match_add, match_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ui_search.sv
// ui_search: scans the Ui table from address 0 up to LAST_ADDR for a latched key.
// It stops on the first hit, or counts every hit when COUNT_ALL=1.
`default_nettype none

module ui_search #(
  parameter int LAST_ADDR = 255,
  parameter bit COUNT_ALL = 1'b0
) (
  input  logic         CS,
  input  logic         cen,
  ui_search_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LastAddr = LAST_ADDR[7:0];
  localparam logic [8:0] CntMax   = 9'd256;

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] add_q, add_d;
  // Address and valid flag of the read now returning on Uip (one-cycle Ui latency).
  logic [7:0] rd_add_q, rd_add_d;
  logic       rd_valid_q, rd_valid_d;
  logic       found_q, found_d;
  logic [7:0] match_add_q, match_add_d;
  logic [8:0] match_cnt_q, match_cnt_d;
  logic       hit;

  assign hit = rd_valid_q && (bus.Uip == key_q);

  always_ff @(posedge CS) begin
    if (cen) begin
      state_q     <= IDLE;
      key_q       <= 8'd0;
      add_q       <= 8'd0;
      rd_add_q    <= 8'd0;
      rd_valid_q  <= 1'b0;
      found_q     <= 1'b0;
      match_add_q <= 8'd0;
      match_cnt_q <= 9'd0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      add_q       <= add_d;
      rd_add_q    <= rd_add_d;
      rd_valid_q  <= rd_valid_d;
      found_q     <= found_d;
      match_add_q <= match_add_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    add_d       = add_q;
    rd_add_d    = add_q;
    rd_valid_d  = (state_q == SCAN);
    found_d     = found_q;
    match_add_d = match_add_q;
    match_cnt_d = match_cnt_q;

    if ((state_q == SCAN || state_q == DRAIN) && hit) begin
      if (!found_q) begin
        found_d     = 1'b1;
        match_add_d = rd_add_q;
      end
      if (match_cnt_q != CntMax) begin
        match_cnt_d = match_cnt_q + 9'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d       = bus.key;
          add_d       = 8'd0;
          found_d     = 1'b0;
          match_add_d = 8'd0;
          match_cnt_d = 9'd0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (add_q == LastAddr) begin
          state_d = DRAIN;
        end else begin
          add_d = add_q + 8'd1;
        end
        // First-hit mode drops the reads still in flight.
        if (hit && !COUNT_ALL) begin
          state_d    = DONE;
          rd_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.add       = add_q;
  assign bus.busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.found     = found_q;
  assign bus.match_add = match_add_q;
  assign bus.match_cnt = match_cnt_q;

endmodule

`default_nettype wire

// File: doc/ui_search.md
UI_SEARCH -- requirements
Module: ui_search

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 255, the highest table address scanned (0..255).
REQ-002 SHALL have parameter COUNT_ALL, default 0: 0 = stop on first match; 1 = scan the full range and count matches.
REQ-003 SHALL have port CS  in  1: the single clock, rising-edge active.
REQ-004 SHALL have port cen  in  1: synchronous active-high reset, sampled on rising CS.
REQ-005 SHALL have port start  in  1: request a search, sampled only in IDLE.
REQ-006 SHALL have port key  in  8: the code to find, latched on the accepted start edge.
REQ-007 SHALL have port add  out  8: registered table address driven to the Ui lookup.
REQ-008 SHALL have port Uip  in  8: table data returned by Ui, registered in Ui on CS.
REQ-009 SHALL have port busy  out  1: high from the accepted start until done.
REQ-010 SHALL have port done  out  1: one-cycle completion pulse.
REQ-011 SHALL have port found  out  1: at least one match in the last search.
REQ-012 SHALL have port match_add  out  8: lowest matching address of the last search.
REQ-013 SHALL have port match_cnt  out  9: number of matches in the last search (0..256).

Function
REQ-014 SHALL implement the states IDLE, SCAN, DRAIN and DONE; every state register is updated only on rising CS.
REQ-015 In IDLE with start=1, the block SHALL latch key, set add=0, clear found, match_add and match_cnt, and enter SCAN with busy=1.
REQ-016 In SCAN, the block SHALL increment add each cycle until add=LAST_ADDR, then enter DRAIN with add held.
REQ-017 The block SHALL delay add by one register (add_d) with a valid flag, so each Uip is tagged with its address; the Ui read latency is 1 cycle, giving compare at edge k+2 for address k, counting the start edge as edge 0.
REQ-018 The block SHALL define a match as valid_d=1 and Uip==latched key; the compare is full 8-bit equality.
REQ-019 With COUNT_ALL=0, the first match SHALL set found=1 and match_add=add_d, increment match_cnt to 1, discard any in-flight reads, and enter DONE.
REQ-020 With COUNT_ALL=1, each match SHALL increment match_cnt (9-bit, no wrap); the first match sets found and match_add, and later matches leave match_add unchanged.
REQ-021 In DRAIN, the compare of LAST_ADDR SHALL be processed, then the block enters DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL fall in the same cycle; the state then returns to IDLE.
REQ-023 While busy, start SHALL be ignored; a start coinciding with the done cycle SHALL also be ignored.
REQ-024 Changes on key after the start edge SHALL NOT affect the running search.
REQ-025 found, match_add and match_cnt SHALL hold their values from DONE until the next accepted start.
REQ-026 With LAST_ADDR=0, the block SHALL issue one address, enter DRAIN at once, and assert done 2 cycles after the start edge.

Reset
REQ-027 With cen=1 at a rising CS, the block SHALL enter IDLE; add, busy, done, found, match_add, match_cnt and valid_d all become 0.
REQ-028 A reset mid-search SHALL abandon the search with no done pulse; start is honoured again on the first edge after cen falls.

Verification (Ui table: ROM[0]=0x00, ROM[1..255]=0x02)
REQ-029 The bench SHALL apply key=0x00, start at edge 0 -> done at edge 2, found=1, match_add=0x00, match_cnt=1.
REQ-030 The bench SHALL apply key=0x02, COUNT_ALL=0 -> done at edge 3, found=1, match_add=0x01, match_cnt=1.
REQ-031 The bench SHALL apply key=0x05 -> done at edge 257, found=0, match_add=0x00, match_cnt=0, add held at 0xFF during DRAIN.
REQ-032 The bench SHALL apply COUNT_ALL=1, key=0x02 -> done at edge 257, found=1, match_add=0x01, match_cnt=255.
REQ-033 The bench SHALL pulse cen at edge 40 of a 0x05 search -> no done pulse, all outputs 0 at edge 41; a new start with key=0x00 then completes 2 cycles later.
REQ-034 The bench SHALL hold start=1 and toggle key during a search -> exactly one done per search, results match the latched key, and a new search starts on the first IDLE edge after done.
